// File: rtl/rob_retire.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rob_retire : 2-way reorder buffer, in-order retire, freelist rollback    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rob_retire #(
  parameter int SCALAR_WIDTH    = 2,
  parameter int NUM_ROB_ENTRIES = 32,
  parameter int PREG_IDX_WIDTH  = 6,
  localparam int ROB_IDX_WIDTH  = $clog2(NUM_ROB_ENTRIES),
  localparam int ARCH_IDX_WIDTH = 5
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [SCALAR_WIDTH-1:0]                       dispatch_en,
  input  logic [SCALAR_WIDTH-1:0][PREG_IDX_WIDTH-1:0]   dispatch_T_idx,
  input  logic [SCALAR_WIDTH-1:0][PREG_IDX_WIDTH-1:0]   dispatch_Told_idx,
  input  logic [SCALAR_WIDTH-1:0][ARCH_IDX_WIDTH-1:0]   dispatch_dest_idx,
  input  logic [SCALAR_WIDTH-1:0]                       dispatch_is_br,
  input  logic [SCALAR_WIDTH-1:0]                       cdb_valid,
  input  logic [SCALAR_WIDTH-1:0][ROB_IDX_WIDTH-1:0]    cdb_rob_idx,
  input  logic [SCALAR_WIDTH-1:0]                       cdb_mispredict,
  output logic [1:0]                                    ROB_avail,
  output logic [SCALAR_WIDTH-1:0][ROB_IDX_WIDTH-1:0]    ROB_idx,
  output logic [SCALAR_WIDTH-1:0]                       retire_en,
  output logic [SCALAR_WIDTH-1:0][PREG_IDX_WIDTH-1:0]   ROB_FL_out_Told_idx,
  output logic [SCALAR_WIDTH-1:0][ARCH_IDX_WIDTH-1:0]   retire_dest_idx,
  output logic [SCALAR_WIDTH-1:0][PREG_IDX_WIDTH-1:0]   retire_T_idx,
  output logic                                          rollback_en,
  output logic [PREG_IDX_WIDTH-1:0]                     ROB_FL_out_T_idx
);

  localparam int CNT_WIDTH = ROB_IDX_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]      FULL      = CNT_WIDTH'(NUM_ROB_ENTRIES);
  localparam logic [CNT_WIDTH-1:0]      FULL_M1   = CNT_WIDTH'(NUM_ROB_ENTRIES - 1);
  localparam logic [PREG_IDX_WIDTH-1:0] ZERO_PREG = '0;
  localparam logic [ROB_IDX_WIDTH-1:0]  IDX_ONE   = ROB_IDX_WIDTH'(1);

  logic [ROB_IDX_WIDTH-1:0]  head, tail, head_p1, tail_p1;
  logic [CNT_WIDTH-1:0]      count;
  logic [PREG_IDX_WIDTH-1:0] last_t_reg;

  logic [NUM_ROB_ENTRIES-1:0] valid, complete, mispredict, is_br;
  logic [PREG_IDX_WIDTH-1:0]  t_mem      [NUM_ROB_ENTRIES];
  logic [PREG_IDX_WIDTH-1:0]  told_mem   [NUM_ROB_ENTRIES];
  logic [PREG_IDX_WIDTH-1:0]  last_t_mem [NUM_ROB_ENTRIES];
  logic [ARCH_IDX_WIDTH-1:0]  dest_mem   [NUM_ROB_ENTRIES];

  logic [SCALAR_WIDTH-1:0]                    ret;
  logic [SCALAR_WIDTH-1:0][ROB_IDX_WIDTH-1:0] ret_idx;
  logic                                       rollback;
  logic                                       acc0, acc1;
  logic [ROB_IDX_WIDTH-1:0]                   wr_idx1;
  logic [PREG_IDX_WIDTH-1:0]                  lt0, lt1;

  assign head_p1 = head + IDX_ONE;
  assign tail_p1 = tail + IDX_ONE;

  // Retire decisions use only registered state, so a same-cycle CDB hit
  // on the head entry is seen one cycle later.
  assign ret_idx[0] = head;
  assign ret_idx[1] = head_p1;
  assign ret[0]     = valid[head] & complete[head];
  assign rollback   = ret[0] & is_br[head] & mispredict[head];
  assign ret[1]     = ret[0] & ~rollback & valid[head_p1] & complete[head_p1];

  // Space is judged on the pre-retire count; slots freed this cycle are not reused.
  always_comb begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rollback) begin
      if (dispatch_en == 2'b11) begin
        acc0 = (count < FULL);
        acc1 = (count < FULL_M1);
      end else begin
        acc0 = dispatch_en[0] & (count < FULL);
        acc1 = dispatch_en[1] & (count < FULL);
      end
    end
  end

  assign wr_idx1 = acc0 ? tail_p1 : tail;
  assign lt0 = (dispatch_T_idx[0] != ZERO_PREG) ? dispatch_T_idx[0] : last_t_reg;
  assign lt1 = (dispatch_T_idx[1] != ZERO_PREG) ? dispatch_T_idx[1] :
               (acc0 ? lt0 : last_t_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      last_t_reg <= ZERO_PREG;
      valid      <= '0;
      complete   <= '0;
      mispredict <= '0;
    end else if (rollback) begin
      head       <= head_p1;
      tail       <= head_p1;
      count      <= '0;
      last_t_reg <= last_t_mem[head];
      valid      <= '0;
    end else begin
      for (int i = 0; i < SCALAR_WIDTH; i++) begin
        if (cdb_valid[i] && valid[cdb_rob_idx[i]]) begin
          complete[cdb_rob_idx[i]] <= 1'b1;
          if (is_br[cdb_rob_idx[i]] && cdb_mispredict[i])
            mispredict[cdb_rob_idx[i]] <= 1'b1;
        end
      end
      if (ret[0]) valid[head]    <= 1'b0;
      if (ret[1]) valid[head_p1] <= 1'b0;
      if (acc0) begin
        valid[tail]      <= 1'b1;
        complete[tail]   <= 1'b0;
        mispredict[tail] <= 1'b0;
      end
      if (acc1) begin
        valid[wr_idx1]      <= 1'b1;
        complete[wr_idx1]   <= 1'b0;
        mispredict[wr_idx1] <= 1'b0;
      end
      head  <= head + ROB_IDX_WIDTH'(ret[0]) + ROB_IDX_WIDTH'(ret[1]);
      tail  <= tail + ROB_IDX_WIDTH'(acc0) + ROB_IDX_WIDTH'(acc1);
      count <= count + CNT_WIDTH'(acc0) + CNT_WIDTH'(acc1)
                     - CNT_WIDTH'(ret[0]) - CNT_WIDTH'(ret[1]);
      if (acc1)      last_t_reg <= lt1;
      else if (acc0) last_t_reg <= lt0;
    end
  end

  always_ff @(posedge clock) begin
    if (acc0) begin
      t_mem[tail]      <= dispatch_T_idx[0];
      told_mem[tail]   <= dispatch_Told_idx[0];
      dest_mem[tail]   <= dispatch_dest_idx[0];
      last_t_mem[tail] <= lt0;
      is_br[tail]      <= dispatch_is_br[0];
    end
    if (acc1) begin
      t_mem[wr_idx1]      <= dispatch_T_idx[1];
      told_mem[wr_idx1]   <= dispatch_Told_idx[1];
      dest_mem[wr_idx1]   <= dispatch_dest_idx[1];
      last_t_mem[wr_idx1] <= lt1;
      is_br[wr_idx1]      <= dispatch_is_br[1];
    end
  end

  for (genvar s = 0; s < SCALAR_WIDTH; s++) begin : g_retire_slot
    assign retire_en[s]           = ret[s];
    assign ROB_FL_out_Told_idx[s] = ret[s] ? told_mem[ret_idx[s]] : ZERO_PREG;
    assign retire_T_idx[s]        = ret[s] ? t_mem[ret_idx[s]] : ZERO_PREG;
    assign retire_dest_idx[s]     = ret[s] ? dest_mem[ret_idx[s]] : '0;
  end

  assign rollback_en      = rollback;
  assign ROB_FL_out_T_idx = rollback ? last_t_mem[head] : ZERO_PREG;

  always_comb begin
    ROB_avail = 2'b11;
    if (count == FULL)         ROB_avail = 2'b00;
    else if (count == FULL_M1) ROB_avail = 2'b01;
  end

  assign ROB_idx[0] = tail;
  assign ROB_idx[1] = (acc0 & acc1) ? tail_p1 : tail;

endmodule
`default_nettype wire

// File: tb/tb_rob_retire.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rob_retire : randomized scoreboard bench against a queue-based model   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rob_retire;
  localparam int N = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      dispatch_en;
  logic [1:0][5:0] dispatch_T_idx, dispatch_Told_idx;
  logic [1:0][4:0] dispatch_dest_idx;
  logic [1:0]      dispatch_is_br;
  logic [1:0]      cdb_valid;
  logic [1:0][4:0] cdb_rob_idx;
  logic [1:0]      cdb_mispredict;
  logic [1:0]      ROB_avail;
  logic [1:0][4:0] ROB_idx;
  logic [1:0]      retire_en;
  logic [1:0][5:0] ROB_FL_out_Told_idx;
  logic [1:0][4:0] retire_dest_idx;
  logic [1:0][5:0] retire_T_idx;
  logic            rollback_en;
  logic [5:0]      ROB_FL_out_T_idx;

  always #5 clock = ~clock;

  rob_retire dut (
    .clock(clock), .reset(reset),
    .dispatch_en(dispatch_en), .dispatch_T_idx(dispatch_T_idx),
    .dispatch_Told_idx(dispatch_Told_idx), .dispatch_dest_idx(dispatch_dest_idx),
    .dispatch_is_br(dispatch_is_br),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_mispredict(cdb_mispredict),
    .ROB_avail(ROB_avail), .ROB_idx(ROB_idx), .retire_en(retire_en),
    .ROB_FL_out_Told_idx(ROB_FL_out_Told_idx), .retire_dest_idx(retire_dest_idx),
    .retire_T_idx(retire_T_idx), .rollback_en(rollback_en),
    .ROB_FL_out_T_idx(ROB_FL_out_T_idx)
  );

  typedef struct { int idx; int t; int told; int dest; bit br; bit done; bit mp; int lt; } ent_t;
  typedef struct { int t; int told; int dest; } ret_t;
  typedef struct { int avail; int ren; int rb; int rbt; int idx0; int idx1; } st_t;

  ent_t m_q[$];
  ret_t exp_q[$];
  st_t  st_q[$];
  int   m_tail, m_last;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one status record per cycle, one retire record per asserted retire slot.
  initial begin : monitor
    st_t  s;
    ret_t r;
    forever begin
      @(negedge clock);
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("ROB_avail", 32'(ROB_avail), s.avail);
        chk("retire_en", 32'(retire_en), s.ren);
        chk("rollback_en", 32'(rollback_en), s.rb);
        chk("rollback_T", 32'(ROB_FL_out_T_idx), s.rbt);
        chk("ROB_idx0", 32'(ROB_idx[0]), s.idx0);
        chk("ROB_idx1", 32'(ROB_idx[1]), s.idx1);
        for (int k = 0; k < 2; k++) begin
          if (retire_en[k] === 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL retire_unexpected slot %0d: got retire expected none", k);
            end else begin
              r = exp_q.pop_front();
              chk("retire_Told", 32'(ROB_FL_out_Told_idx[k]), r.told);
              chk("retire_T", 32'(retire_T_idx[k]), r.t);
              chk("retire_dest", 32'(retire_dest_idx[k]), r.dest);
            end
          end else begin
            chk("idle_Told", 32'(ROB_FL_out_Told_idx[k]), 0);
            chk("idle_T", 32'(retire_T_idx[k]), 0);
            chk("idle_dest", 32'(retire_dest_idx[k]), 0);
          end
        end
      end
    end
  end

  initial begin : driver
    st_t  s;
    ent_t e;
    int   size, phase, pick;
    bit   r0, r1, rb, a0, a1, rst;
    int   open_idx[$];
    logic [1:0] den;

    reset = 1'b1;
    dispatch_en = '0; dispatch_T_idx = '0; dispatch_Told_idx = '0;
    dispatch_dest_idx = '0; dispatch_is_br = '0;
    cdb_valid = '0; cdb_rob_idx = '0; cdb_mispredict = '0;
    repeat (3) @(posedge clock);
    #1;
    m_q.delete(); m_tail = 0; m_last = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      phase = (cyc / 150) % 3;
      rst   = (cyc == 1500);
      den = '0; cdb_valid = '0; cdb_mispredict = '0; cdb_rob_idx = '0;
      for (int k = 0; k < 2; k++) begin
        dispatch_T_idx[k]    = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        dispatch_Told_idx[k] = 6'($urandom_range(0, 63));
        dispatch_dest_idx[k] = 5'($urandom_range(0, 31));
        dispatch_is_br[k]    = ($urandom_range(0, 3) == 0);
      end
      if (!rst) begin
        case (phase)
          0:       den = 2'($urandom_range(0, 3));
          1:       den = ($urandom_range(0, 7) != 0) ? 2'($urandom_range(1, 3)) : 2'd0;
          default: den = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        endcase
        open_idx.delete();
        foreach (m_q[j]) if (!m_q[j].done) open_idx.push_back(m_q[j].idx);
        for (int p = 0; p < 2; p++) begin
          if ((phase == 0 && $urandom_range(0, 1) == 0) ||
              (phase == 1 && $urandom_range(0, 15) == 0) || phase == 2) begin
            cdb_valid[p] = 1'b1;
            if (open_idx.size() > 0 && $urandom_range(0, 9) != 0) begin
              pick = (phase == 2 && p == 0) ? 0 : $urandom_range(0, open_idx.size() - 1);
              cdb_rob_idx[p] = 5'(open_idx[pick]);
            end else begin
              cdb_rob_idx[p] = 5'($urandom_range(0, 31));
            end
            cdb_mispredict[p] = ($urandom_range(0, 5) == 0);
          end
        end
      end

      // Model outputs for the current (post-edge) state.
      size = m_q.size();
      r0 = (size > 0) && m_q[0].done;
      rb = r0 && m_q[0].br && m_q[0].mp;
      r1 = r0 && !rb && (size > 1) && m_q[1].done;
      a0 = 1'b0; a1 = 1'b0;
      if (!rb) begin
        if (den == 2'b11) begin
          a0 = (size <= N - 1); a1 = (size <= N - 2);
        end else begin
          a0 = den[0] && (size <= N - 1); a1 = den[1] && (size <= N - 1);
        end
      end
      s.avail = (size == N) ? 0 : (size == N - 1) ? 1 : 3;
      s.ren   = {30'd0, r1, r0};
      s.rb    = rb;
      s.rbt   = rb ? m_q[0].lt : 0;
      s.idx0  = m_tail;
      s.idx1  = (a0 && a1) ? (m_tail + 1) % N : m_tail;
      st_q.push_back(s);
      if (r0) exp_q.push_back('{m_q[0].t, m_q[0].told, m_q[0].dest});
      if (r1) exp_q.push_back('{m_q[1].t, m_q[1].told, m_q[1].dest});

      // Model next state.
      if (rst) begin
        m_q.delete(); m_tail = 0; m_last = 0;
      end else if (rb) begin
        m_tail = (m_q[0].idx + 1) % N;
        m_last = m_q[0].lt;
        m_q.delete();
      end else begin
        for (int p = 0; p < 2; p++)
          if (cdb_valid[p])
            foreach (m_q[j])
              if (m_q[j].idx == int'(cdb_rob_idx[p])) begin
                m_q[j].done = 1'b1;
                if (m_q[j].br && cdb_mispredict[p]) m_q[j].mp = 1'b1;
              end
        if (r0) void'(m_q.pop_front());
        if (r1) void'(m_q.pop_front());
        for (int k = 0; k < 2; k++) begin
          if ((k == 0) ? a0 : a1) begin
            e.idx  = m_tail;
            e.t    = int'(dispatch_T_idx[k]);
            e.told = int'(dispatch_Told_idx[k]);
            e.dest = int'(dispatch_dest_idx[k]);
            e.br   = dispatch_is_br[k];
            e.done = 1'b0;
            e.mp   = 1'b0;
            e.lt   = (e.t != 0) ? e.t : m_last;
            m_last = e.lt;
            m_tail = (m_tail + 1) % N;
            m_q.push_back(e);
          end
        end
      end

      reset       = rst;
      dispatch_en = den;
      @(posedge clock);
      #1;
    end

    reset = 1'b0; dispatch_en = '0; cdb_valid = '0;
    @(negedge clock);
    #1;
    chk("status_queue_drained", st_q.size(), 0);
    chk("retire_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- 2-way reorder buffer; the other end of the freelist interface.
- Accepts up to two dispatched instructions per cycle, each carrying its freelist-allocated T and the previous mapping Told.
- Marks entries complete from two CDB ports and retires up to two entries in order, driving retire_en and ROB_FL_out_Told_idx to the freelist.
- On a mispredicted branch reaching the head it flushes all younger entries and drives rollback_en and ROB_FL_out_T_idx so the freelist tail can be restored.

Parameters:
SCALAR_WIDTH, 2, dispatch/complete/retire width (fixed at 2)
NUM_ROB_ENTRIES, 32, entries; power of two
PREG_IDX_WIDTH, 6, physical register tag width; tag 0 is ZERO_PREG

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
dispatch_en  in  2  per-slot dispatch request, slot 0 older
dispatch_T_idx  in  2x6  allocated tag per slot, ZERO_PREG if no dest
dispatch_Told_idx  in  2x6  previous mapping per slot
dispatch_dest_idx  in  2x5  architectural dest per slot
dispatch_is_br  in  2  slot is a branch
cdb_valid  in  2  completion broadcast valid
cdb_rob_idx  in  2x5  completing entry index
cdb_mispredict  in  2  completing branch was mispredicted
ROB_avail  out  2  00 none free, 01 one free, 11 two or more free
ROB_idx  out  2x5  entry index assigned per dispatch slot
retire_en  out  2  per-slot retire this cycle
ROB_FL_out_Told_idx  out  2x6  Told of retiring entries, ZERO_PREG when slot idle
retire_dest_idx  out  2x5  arch dest of retiring entries
retire_T_idx  out  2x6  T of retiring entries, for the arch map
rollback_en  out  1  flush this cycle
ROB_FL_out_T_idx  out  6  rollback tag for freelist CAM lookup

Behaviour:
- State: head, tail (5-bit, wrap modulo NUM_ROB_ENTRIES), count (6-bit, 0..32), and per entry: valid, complete, mispredict, is_br, T, Told, dest, last_T.
- last_T at dispatch:
  - If the slot's T is nonzero, last_T = that T.
  - Otherwise last_T = the last nonzero T dispatched before it, tracked in a register lastT_reg that updates on every accepted dispatch.
  - lastT_reg resets to 0.
- Reset: head=tail=count=0, all valid/complete cleared, lastT_reg=0. All outputs 0 in the cycle after reset; ROB_avail=11.
- ROB_avail is computed from registered count:
  - 00 when count==32.
  - 01 when count==31.
  - 11 otherwise.
- Dispatch:
  - A slot is accepted when its dispatch_en bit is set and space permits. Slot 1 alone is accepted if count<=31. Both slots need count<=30; if only one slot is free, only slot 0 is accepted.
  - Entries are written at tail, then tail+1, in the next cycle, with complete=0.
  - ROB_idx = {tail+1, tail} when both slots dispatch, else {tail, tail}.
- Completion:
  - cdb_valid[i] sets complete[cdb_rob_idx[i]] on the next edge; mispredict is set from cdb_mispredict[i] only when is_br.
  - A CDB hit on an invalid entry is ignored.
- Retire (combinational from registered state, committed at the edge):
  - Slot 0 retires when head is valid and complete.
  - Slot 1 retires when slot 0 retires, head+1 is valid and complete, and head is not a mispredicted branch.
  - head advances and count decrements by the number retired.
  - Idle retire slots drive ZERO_PREG on Told and T, and 0 on dest.
- Rollback:
  - When retire slot 0 is a mispredicted branch: rollback_en=1 and ROB_FL_out_T_idx = last_T of that branch, in the same cycle as retire_en[0].
  - Next state: all valid cleared, tail=head+1, count=0, lastT_reg = branch last_T.
  - Dispatch and CDB inputs are ignored in the rollback cycle.
  - ROB_FL_out_T_idx=0 when rollback_en=0.
- Simultaneous dispatch and retire: count_next = count + accepted - retired. Space is checked against pre-retire count; same-cycle freed slots are not reused.
- Completion and retire of the same entry in the same cycle: the entry does not retire; complete becomes visible next cycle.
- Reset mid-operation overrides all other activity; every entry is invalid next cycle.

Test Plan:
- Reset, then dispatch two entries with T={33,34}, Told={2,3}, then CDB-complete both -> next cycle retire_en=11, ROB_FL_out_Told_idx={3,2}, count returns to 0.
- Complete an entry at head+1 only -> no retire; then complete head -> both retire in one cycle, in order.
- Dispatch 32 single-slot entries -> ROB_avail goes 11, then 01 at count 31, then 00 at count 32. A further dispatch_en=11 is not accepted; head and tail remain equal.
- Branch at head (last_T=40), with three younger entries, completes with mispredict -> next cycle rollback_en=1, ROB_FL_out_T_idx=40, retire_en=01. Following cycle count=0 and ROB_avail=11.
- Complete head (a branch, mispredict) and head+1 in the same cycle -> only the branch retires; head+1 is flushed, never retired.
- Drive tail across the wrap point 31->0 with interleaved dispatch and retire -> ROB_idx wraps to 0 and retirement order is preserved.
